cla_bist_ctrl: RTL and testbench
================================

CLA_BIST_CTRL -- requirements
Module: cla_bist_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 128: adder operand and sum width.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of vector and error counters.
REQ-003 The block SHALL have parameter LAT, default 4: nominal pipelined-adder latency in cycles, used for drain timeout.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a test session.
REQ-007 abort  input  1  terminate current session.
REQ-008 num_vec  input  CNT_W  vectors per session; sampled on accepted start.
REQ-009 lfsr_q  input  W  current LFSR pattern.
REQ-010 lfsr_en  output  1  advances the external LFSR.
REQ-011 op_a, op_b  output  W each  registered adder operands.
REQ-012 add_in_valid  output  1  operands valid this cycle.
REQ-013 add_sum  input  W  adder result.
REQ-014 add_out_valid  input  1  add_sum valid this cycle.
REQ-015 busy  output  1  session in progress (RUN or DRAIN).
REQ-016 done  output  1  one-cycle pulse at session end.
REQ-017 pass  output  1  last session clean; held until next accepted start.
REQ-018 timeout  output  1  last session ended by drain timeout; held.
REQ-019 err_cnt  output  CNT_W  mismatching results in last or current session.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN, DONE; busy=1 exactly in RUN and DRAIN.
REQ-021 IDLE: start=1 with num_vec!=0 -> RUN; counters, err_cnt, pass, timeout cleared; num_vec latched.
REQ-022 IDLE: start=1 with num_vec==0 -> DONE, pass=1, err_cnt=0.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 RUN, each cycle: lfsr_en=1; next edge op_a<=lfsr_q, op_b<=~lfsr_q, add_in_valid<=1, issued count +1.
REQ-025 RUN -> DRAIN on the cycle the num_vec-th vector is issued; lfsr_en=0 and add_in_valid=0 thereafter.
REQ-026 Each add_out_valid=1 in RUN or DRAIN: received count +1; add_sum != all-ones -> err_cnt +1, saturating at 2^CNT_W-1.
REQ-027 add_out_valid in IDLE or DONE SHALL be ignored.
REQ-028 DRAIN -> DONE when received count == num_vec, including the same cycle the last result arrives.
REQ-029 DRAIN with LAT+2 consecutive cycles lacking add_out_valid -> DONE, timeout=1, pass=0.
REQ-030 abort=1 in RUN or DRAIN -> DONE next edge, pass=0, timeout=0; results in flight are discarded; abort outside RUN/DRAIN has no effect.
REQ-031 abort and last result on the same cycle: abort wins.
REQ-032 DONE lasts one cycle with done=1, then IDLE; pass=1 iff err_cnt==0, no timeout, no abort.
REQ-033 Results beyond num_vec SHALL not be counted.

Reset
REQ-034 rst=1 SHALL force IDLE; lfsr_en, add_in_valid, busy, done, pass, timeout, err_cnt, op_a, op_b and internal counters SHALL be 0.
REQ-035 rst asserted mid-session SHALL abandon it silently, with no done pulse.
REQ-036 rst SHALL take priority over start and abort.

Configuration
REQ-037 Macro CLA_BIST_FIRST_ERR_EN defined: add outputs first_err_idx (CNT_W) and first_err_sum (W), capturing the received-count index and add_sum of the first mismatch; cleared on accepted start and on rst; held after DONE.
REQ-038 Macro CLA_BIST_FIRST_ERR_EN undefined: these ports and their registers SHALL not exist; all other behaviour is unchanged.

Verification
REQ-039 Ideal adder, LAT=4, num_vec=16 -> 16 add_in_valid cycles, done pulse one cycle after 16th result, pass=1, err_cnt=0.
REQ-040 Adder forcing bit 5 of the 3rd result low -> err_cnt=1, pass=0; with CLA_BIST_FIRST_ERR_EN, first_err_idx=2, first_err_sum=all-ones except bit 5.
REQ-041 add_out_valid suppressed after 10 of 16 results -> DONE 6 cycles after last valid, timeout=1, pass=0, err_cnt=0.
REQ-042 abort on 5th RUN cycle -> lfsr_en low next cycle, done pulse, pass=0, timeout=0; late results do not change err_cnt.
REQ-043 start with num_vec=0 -> done two cycles later, pass=1; start pulsed during RUN -> ignored, vector count unchanged.
REQ-044 rst during DRAIN -> all outputs 0 next cycle, no done; next start runs a full clean session.

Source files
------------

// File: rtl/cla_bist_ctrl.sv
// BIST sequencer for a pipelined carry-lookahead adder: feeds A=LFSR, B=~LFSR and expects all-ones sums.
// Optional first-mismatch capture (first_err_idx/first_err_sum) is enabled with `define CLA_BIST_FIRST_ERR_EN.
module cla_bist_ctrl #(
    parameter int W     = 128,
    parameter int CNT_W = 32,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [W-1:0]     lfsr_q,
    output logic             lfsr_en,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic             add_in_valid,
    input  logic [W-1:0]     add_sum,
    input  logic             add_out_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt
`ifdef CLA_BIST_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [W-1:0]     first_err_sum
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int IW = $clog2(LAT + 3);
    localparam logic [IW-1:0] IDLE_LIM = IW'(LAT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(LAT + 2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] iss_cnt, rcv_cnt, nv_q, err_nxt;
    logic [IW-1:0]    idle_cnt;
    logic             active, accept, issue, rcv_take, mism, err_inc, drained, idle_hit, to_fire;

    assign active   = (state == RUN) || (state == DRAIN);
    assign accept   = (state == IDLE) && start;
    assign issue    = (state == RUN) && !abort;
    assign mism     = (add_sum != '1);
    // results past num_vec and anything arriving on an abort cycle are dropped
    assign rcv_take = active && !abort && add_out_valid && (rcv_cnt != nv_q);
    assign err_inc  = rcv_take && mism && !(&err_cnt);
    assign err_nxt  = err_cnt + CNT_W'(err_inc);
    assign drained  = (rcv_cnt == nv_q) || (rcv_take && (rcv_cnt + CNT_W'(1) == nv_q));
    // idle_cnt holds the quiet cycles already seen; this cycle makes LAT+2
    assign idle_hit = !add_out_valid && (idle_cnt >= IDLE_LIM);

    assign lfsr_en = issue;
    assign busy    = active;
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        to_fire   = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (num_vec == '0) ? DONE : RUN;
            RUN: begin
                if (abort)                                state_nxt = DONE;
                else if (iss_cnt + CNT_W'(1) == nv_q)     state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort || drained) state_nxt = DONE;
                else if (idle_hit) begin
                    state_nxt = DONE;
                    to_fire   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            add_in_valid <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            iss_cnt      <= '0;
            rcv_cnt      <= '0;
            nv_q         <= '0;
            err_cnt      <= '0;
            idle_cnt     <= '0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            add_in_valid <= issue;
            if (issue) begin
                op_a    <= lfsr_q;
                op_b    <= ~lfsr_q;
                iss_cnt <= iss_cnt + CNT_W'(1);
            end
            if (active)
                idle_cnt <= add_out_valid ? '0 :
                            (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IW'(1);
            if (rcv_take) begin
                rcv_cnt <= rcv_cnt + CNT_W'(1);
                err_cnt <= err_nxt;
            end
            if (active && state_nxt == DONE) begin
                pass    <= !abort && !to_fire && (err_nxt == '0);
                timeout <= to_fire;
            end
            if (accept) begin
                iss_cnt  <= '0;
                rcv_cnt  <= '0;
                err_cnt  <= '0;
                idle_cnt <= '0;
                nv_q     <= num_vec;
                pass     <= (num_vec == '0);
                timeout  <= 1'b0;
            end
        end
    end

`ifdef CLA_BIST_FIRST_ERR_EN
    logic first_seen;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            first_seen    <= 1'b0;
            first_err_idx <= '0;
            first_err_sum <= '0;
        end else if (rcv_take && mism && !first_seen) begin
            first_seen    <= 1'b1;
            first_err_idx <= rcv_cnt;
            first_err_sum <= add_sum;
        end
    end
`endif

endmodule

// File: tb/tb_cla_bist_ctrl.sv
// Randomized bench for cla_bist_ctrl: behavioural pipelined adder with fault/drop injection
// and a session-level model of expected error count, verdict and completion time.
module tb_cla_bist_ctrl;
    localparam int W = 128, CNT_W = 32, LAT = 4;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic [W-1:0]     lfsr_q = '0, add_sum = '0;
    logic             add_out_valid = 1'b0;
    logic             lfsr_en, add_in_valid, busy, done, pass, timeout;
    logic [W-1:0]     op_a, op_b;
    logic [CNT_W-1:0] err_cnt;
`ifdef CLA_BIST_FIRST_ERR_EN
    logic [CNT_W-1:0] first_err_idx;
    logic [W-1:0]     first_err_sum;
`endif

    cla_bist_ctrl #(.W(W), .CNT_W(CNT_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vec(num_vec),
        .lfsr_q(lfsr_q), .lfsr_en(lfsr_en), .op_a(op_a), .op_b(op_b),
        .add_in_valid(add_in_valid), .add_sum(add_sum), .add_out_valid(add_out_valid),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
`ifdef CLA_BIST_FIRST_ERR_EN
        , .first_err_idx(first_err_idx), .first_err_sum(first_err_sum)
`endif
    );

    int n_checks = 0, n_err = 0, cyc = 0;
    int res_cnt = 0, drop_after = 0, iv_cnt = 0, last_res_cyc = -1;
    bit force_bad = 1'b0;
    bit faulty [0:63];
    int fbits  [0:63];
    bit pv [0:LAT];
    logic [W-1:0] pd [0:LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal adder with LAT-cycle latency; corrupts/suppresses results on request.
    always @(posedge clk) begin
        #1;
        if (add_in_valid) begin
            iv_cnt++;
            n_checks++;
            if (op_a !== lfsr_q || op_b !== ~lfsr_q) begin
                n_err++;
                $display("FAIL operands: op_a=%h op_b=%h expected op_a=%h", op_a, op_b, lfsr_q);
            end
        end
        for (int i = LAT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = add_in_valid;
        pd[0] = op_a + op_b;
        if (force_bad) begin
            add_out_valid = 1'b1;
            add_sum       = '0;
        end else if (pv[LAT] && res_cnt < drop_after) begin
            add_out_valid = 1'b1;
            add_sum       = pd[LAT];
            if (res_cnt < 64 && faulty[res_cnt]) add_sum = add_sum ^ (W'(1) << fbits[res_cnt]);
            last_res_cyc = cyc;
            res_cnt++;
        end else begin
            add_out_valid = 1'b0;
            add_sum       = {$urandom, $urandom, $urandom, $urandom};
        end
        lfsr_q = {$urandom, $urandom, $urandom, $urandom};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_faults();
        for (int i = 0; i < 64; i++) begin
            faulty[i] = 1'b0;
            fbits[i]  = 0;
        end
    endtask

    // Runs one session and returns at the negedge where done is first seen (dcyc=-1 if never).
    task automatic do_session(input int nv, input int drop, input int abort_at, input int start_at,
                              output int dcyc, output int c0);
        repeat (LAT + 2) @(negedge clk);
        res_cnt = 0; drop_after = drop; iv_cnt = 0; last_res_cyc = -1;
        num_vec = CNT_W'(nv);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            abort = (abort_at > 0 && cyc == c0 + abort_at);
            if (start_at > 0 && cyc == c0 + start_at) begin
                start = 1'b1;
                num_vec = 5;
            end else start = 1'b0;
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        n_checks++;
        if (dcyc < 0) begin
            n_err++;
            $display("FAIL done_wait: no done pulse within 200 cycles (nv=%0d)", nv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({lfsr_en, add_in_valid, busy, done, pass, timeout} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000000", {lfsr_en, add_in_valid, busy, done, pass, timeout});
        end
        n_checks++;
        if (err_cnt !== '0 || op_a !== '0 || op_b !== '0) begin
            n_err++;
            $display("FAIL reset_data: err_cnt=%0d op_a=%h op_b=%h expected all zero", err_cnt, op_a, op_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean();
        int d, c0;
        clear_faults();
        do_session(16, 16, 0, 0, d, c0);
        n_checks++;
        if (iv_cnt != 16) begin n_err++; $display("FAIL clean_issue: got %0d expected 16", iv_cnt); end
        n_checks++;
        if (d != last_res_cyc + 1) begin n_err++; $display("FAIL clean_done_time: got %0d expected %0d", d, last_res_cyc + 1); end
        n_checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || err_cnt !== '0) begin
            n_err++;
            $display("FAIL clean_result: pass=%b timeout=%b err=%0d expected 1 0 0", pass, timeout, err_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL clean_pulse: done=%b busy=%b expected 0 0", done, busy); end
        // stray results while idle must not touch the verdict
        force_bad = 1'b1;
        repeat (4) @(negedge clk);
        force_bad = 1'b0;
        n_checks++;
        if (err_cnt !== '0 || pass !== 1'b1) begin n_err++; $display("FAIL idle_ignore: err=%0d pass=%b expected 0 1", err_cnt, pass); end
    endtask

    task automatic test_single_err();
        int d, c0;
        clear_faults();
        faulty[2] = 1'b1;
        fbits[2]  = 5;
        do_session(16, 16, 0, 0, d, c0);
        n_checks++;
        if (err_cnt !== 1 || pass !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL single_err: err=%0d pass=%b timeout=%b expected 1 0 0", err_cnt, pass, timeout);
        end
`ifdef CLA_BIST_FIRST_ERR_EN
        n_checks++;
        if (first_err_idx !== 2 || first_err_sum !== ~(W'(1) << 5)) begin
            n_err++;
            $display("FAIL first_err: idx=%0d sum=%h expected 2 %h", first_err_idx, first_err_sum, ~(W'(1) << 5));
        end
`endif
    endtask

    task automatic test_timeout();
        int d, c0;
        clear_faults();
        do_session(16, 10, 0, 0, d, c0);
        n_checks++;
        if (d != last_res_cyc + LAT + 3) begin n_err++; $display("FAIL timeout_time: got %0d expected %0d", d, last_res_cyc + LAT + 3); end
        n_checks++;
        if (timeout !== 1'b1 || pass !== 1'b0 || err_cnt !== '0) begin
            n_err++;
            $display("FAIL timeout_result: timeout=%b pass=%b err=%0d expected 1 0 0", timeout, pass, err_cnt);
        end
    endtask

    task automatic test_abort();
        int d, c0;
        for (int i = 0; i < 64; i++) begin faulty[i] = 1'b1; fbits[i] = i; end
        do_session(16, 16, 5, 0, d, c0);
        n_checks++;
        if (d != c0 + 6 || lfsr_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_time: done at %0d lfsr_en=%b expected %0d 0", d - c0, lfsr_en, 6);
        end
        n_checks++;
        if (iv_cnt != 4) begin n_err++; $display("FAIL abort_issue: got %0d expected 4", iv_cnt); end
        repeat (LAT + 4) @(negedge clk);
        n_checks++;
        if (pass !== 1'b0 || timeout !== 1'b0 || err_cnt !== '0) begin
            n_err++;
            $display("FAIL abort_result: pass=%b timeout=%b err=%0d expected 0 0 0", pass, timeout, err_cnt);
        end
        clear_faults();
    endtask

    task automatic test_start_ignored();
        int d, c0;
        do_session(0, 0, 0, 0, d, c0);
        n_checks++;
        if (d - c0 < 1 || d - c0 > 2 || pass !== 1'b1 || err_cnt !== '0 || iv_cnt != 0) begin
            n_err++;
            $display("FAIL zero_vec: done after %0d pass=%b err=%0d issued=%0d expected 1..2 1 0 0", d - c0, pass, err_cnt, iv_cnt);
        end
        do_session(12, 12, 0, 3, d, c0);
        n_checks++;
        if (iv_cnt != 12 || pass !== 1'b1) begin n_err++; $display("FAIL start_in_run: issued=%0d pass=%b expected 12 1", iv_cnt, pass); end
        // start offered while in DONE
        num_vec = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL start_in_done: busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_reset_drain();
        int d, c0, ndone;
        clear_faults();
        for (int i = 0; i < 4; i++) begin faulty[i] = 1'b1; fbits[i] = 7 * i; end
        repeat (LAT + 2) @(negedge clk);
        res_cnt = 0; drop_after = 16;
        num_vec = 16;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 18) @(negedge clk);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({lfsr_en, add_in_valid, busy, done, pass, timeout} !== 6'b0 || err_cnt !== '0 || op_a !== '0 || op_b !== '0) begin
            n_err++;
            $display("FAIL reset_drain: flags=%b err=%0d expected all zero", {lfsr_en, add_in_valid, busy, done, pass, timeout}, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        ndone = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin n_err++; $display("FAIL reset_silent: %0d done/busy cycles expected 0", ndone); end
        clear_faults();
        do_session(16, 16, 0, 0, d, c0);
        n_checks++;
        if (iv_cnt != 16 || pass !== 1'b1 || err_cnt !== '0) begin
            n_err++;
            $display("FAIL after_reset: issued=%0d pass=%b err=%0d expected 16 1 0", iv_cnt, pass, err_cnt);
        end
    endtask

    task automatic test_random();
        int d, c0, nv, drop, nrecv, exp_err, first;
        bit exp_to;
        for (int s = 0; s < 8; s++) begin
            nv = $urandom_range(24, 1);
            drop = ($urandom_range(1, 0) == 1 || nv == 1) ? nv : $urandom_range(nv - 1, (nv > 5) ? nv - 4 : 1);
            clear_faults();
            for (int i = 0; i < 64; i++) begin
                faulty[i] = ($urandom_range(3, 0) == 0);
                fbits[i]  = $urandom_range(W - 1, 0);
            end
            nrecv = (drop < nv) ? drop : nv;
            exp_to = (drop < nv);
            exp_err = 0;
            first = -1;
            for (int i = 0; i < nrecv; i++)
                if (faulty[i]) begin
                    exp_err++;
                    if (first < 0) first = i;
                end
            do_session(nv, drop, 0, 0, d, c0);
            n_checks++;
            if (err_cnt !== CNT_W'(exp_err) || pass !== (exp_err == 0 && !exp_to) || timeout !== exp_to) begin
                n_err++;
                $display("FAIL rand_result[%0d]: err=%0d pass=%b to=%b expected %0d %b %b", s, err_cnt, pass, timeout,
                         exp_err, (exp_err == 0 && !exp_to), exp_to);
            end
            n_checks++;
            if (d != (exp_to ? last_res_cyc + LAT + 3 : last_res_cyc + 1) || iv_cnt != nv) begin
                n_err++;
                $display("FAIL rand_timing[%0d]: done=%0d issued=%0d expected done=%0d issued=%0d", s, d, iv_cnt,
                         exp_to ? last_res_cyc + LAT + 3 : last_res_cyc + 1, nv);
            end
`ifdef CLA_BIST_FIRST_ERR_EN
            if (first >= 0) begin
                n_checks++;
                if (first_err_idx !== CNT_W'(first) || first_err_sum !== ~(W'(1) << fbits[first])) begin
                    n_err++;
                    $display("FAIL rand_first[%0d]: idx=%0d expected %0d", s, first_err_idx, first);
                end
            end
`endif
        end
    endtask

    initial begin
        clear_faults();
        for (int i = 0; i <= LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        test_reset();
        test_clean();
        test_single_err();
        test_timeout();
        test_abort();
        test_start_ignored();
        test_reset_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
